// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the five-stage datapath and its hazard
// controller.
//   status (datapath -> controller): ID/EX/MEM/WB register indices and flags,
//                                    taken-branch flag, dmem_busy
//   control (controller -> datapath): pc_we, stage enables/flushes,
//                                     EX forwarding selects
// master = controller side, slave = datapath side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_ebreak;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_pc_sel;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic              dmem_busy;

    logic              pc_we;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_flush;
    logic              ex_mem_en;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;

    modport master (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_ebreak,
        input  ex_rd, ex_is_load, ex_rs1, ex_rs2, ex_pc_sel,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, dmem_busy,
        output pc_we, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
        output fwd_a_sel, fwd_b_sel
    );

    modport slave (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_ebreak,
        output ex_rd, ex_is_load, ex_rs1, ex_rs2, ex_pc_sel,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write, dmem_busy,
        input  pc_we, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
        input  fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller for a five-stage core.
// Handles load-use stalls, taken-branch flushes, data-memory freezes, the
// ebreak drain-then-halt sequence, EX operand forwarding selects and a
// saturating stall-cycle counter.
// Ports:
//   sys_clk, sys_rst  clock / synchronous active-high reset
//   hz                pipeline status in, pipeline control out (master side)
//   halted            registered, 1 while in HALT
//   stall_cycles      saturating count of non-HALT cycles with pc_we=0
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    pipe_hazard_ctrl_if.master hz,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_DRAIN, ST_HALT} state_t;

    state_t            state_reg, state_next;
    logic [DW-1:0]     drain_reg, drain_next;
    logic              halted_reg;
    logic [CNT_W-1:0]  stall_reg;

    logic pc_we, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
    logic load_use;

    // Forwarding: one identical selector per EX source operand.
    logic [REG_AW-1:0] ex_src [2];
    logic [1:0]        fwd_sel [2];

    assign ex_src[0] = hz.ex_rs1;
    assign ex_src[1] = hz.ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit, wb_hit;
            assign mem_hit = hz.mem_reg_write && (hz.mem_rd != '0) && (hz.mem_rd == ex_src[gi]);
            assign wb_hit  = hz.wb_reg_write  && (hz.wb_rd  != '0) && (hz.wb_rd  == ex_src[gi]);
            // MEM holds the younger result, so it wins over WB.
            assign fwd_sel[gi] = sys_rst ? 2'b00 :
                                 mem_hit ? 2'b01 :
                                 wb_hit  ? 2'b10 : 2'b00;
        end
    endgenerate

    assign load_use = hz.ex_is_load && (hz.ex_rd != '0) &&
                      ((hz.id_rs1_used && (hz.ex_rd == hz.id_rs1)) ||
                       (hz.id_rs2_used && (hz.ex_rd == hz.id_rs2)));

    always_comb begin
        state_next  = state_reg;
        drain_next  = drain_reg;
        pc_we       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;

        case (state_reg)
            // MEM_WAIT behaves exactly like RUN: while busy it freezes,
            // and the first non-busy cycle is evaluated as RUN.
            ST_RUN, ST_MEM_WAIT: begin
                state_next = ST_RUN;
                if (hz.dmem_busy) begin
                    pc_we      = 1'b0;
                    if_id_en   = 1'b0;
                    id_ex_en   = 1'b0;
                    ex_mem_en  = 1'b0;
                    state_next = ST_MEM_WAIT;
                end else if (hz.ex_pc_sel) begin
                    // Younger work is wrong-path; hazards in ID are moot.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    // The bubble moves the load on, so the hazard clears next cycle.
                    pc_we       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (hz.id_ebreak) begin
                    pc_we      = 1'b0;
                    if_id_en   = 1'b0;
                    drain_next = DW'(DRAIN_CYCLES);
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pc_we       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_en    = !hz.dmem_busy;
                id_ex_flush = 1'b1;
                ex_mem_en   = !hz.dmem_busy;
                if (!hz.dmem_busy) begin
                    drain_next = drain_reg - DW'(1);
                    if (drain_reg == DW'(1)) begin
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                pc_we     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
            end
            default: state_next = ST_RUN;
        endcase

        if (sys_rst) begin
            pc_we       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b0;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg  <= ST_RUN;
            drain_reg  <= '0;
            halted_reg <= 1'b0;
            stall_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            drain_reg  <= drain_next;
            halted_reg <= (state_next == ST_HALT);
            if (!pc_we && (state_reg != ST_HALT) && (stall_reg != '1)) begin
                stall_reg <= stall_reg + CNT_W'(1);
            end
        end
    end

    assign hz.pc_we       = pc_we;
    assign hz.if_id_en    = if_id_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_en    = id_ex_en;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.ex_mem_en   = ex_mem_en;
    assign hz.fwd_a_sel   = fwd_sel[0];
    assign hz.fwd_b_sel   = fwd_sel[1];
    assign halted         = halted_reg;
    assign stall_cycles   = stall_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        halted, halted2;
    logic [31:0] stall_cycles;
    logic [2:0]  stall_cycles2;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_stall = 0;

    always #5 sys_clk = ~sys_clk;

    pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();
    pipe_hazard_ctrl_if #(.REG_AW(5)) hz2 ();

    // Second instance with a 3-bit counter shares the stimulus to expose saturation.
    assign hz2.id_rs1        = hz.id_rs1;
    assign hz2.id_rs2        = hz.id_rs2;
    assign hz2.id_rs1_used   = hz.id_rs1_used;
    assign hz2.id_rs2_used   = hz.id_rs2_used;
    assign hz2.id_ebreak     = hz.id_ebreak;
    assign hz2.ex_rd         = hz.ex_rd;
    assign hz2.ex_is_load    = hz.ex_is_load;
    assign hz2.ex_rs1        = hz.ex_rs1;
    assign hz2.ex_rs2        = hz.ex_rs2;
    assign hz2.ex_pc_sel     = hz.ex_pc_sel;
    assign hz2.mem_rd        = hz.mem_rd;
    assign hz2.mem_reg_write = hz.mem_reg_write;
    assign hz2.wb_rd         = hz.wb_rd;
    assign hz2.wb_reg_write  = hz.wb_reg_write;
    assign hz2.dmem_busy     = hz.dmem_busy;

    pipe_hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hz(hz),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(3), .CNT_W(3)) dut_sat (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hz(hz2),
        .halted(halted2), .stall_cycles(stall_cycles2)
    );

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       rs1u, rs2u;
        logic [4:0] ex_rd;
        logic       ld;
        logic [4:0] ex_rs1, ex_rs2;
        logic       pcsel;
        logic [4:0] mem_rd;
        logic       mrw;
        logic [4:0] wb_rd;
        logic       wrw;
        logic [5:0] exp_ctrl;  // {pc_we,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en}
        logic [3:0] exp_fwd;   // {fwd_a_sel,fwd_b_sel}
    } vec_t;

    vec_t vecs[11];

    localparam logic [5:0] C_IDLE  = 6'b110101;
    localparam logic [5:0] C_LU    = 6'b000111;
    localparam logic [5:0] C_BR    = 6'b111111;
    localparam logic [5:0] C_FRZ   = 6'b000000;
    localparam logic [5:0] C_RST   = 6'b001010;
    localparam logic [5:0] C_EBRK  = 6'b000101;
    localparam logic [5:0] C_DRN   = 6'b000111;
    localparam logic [5:0] C_DRNB  = 6'b000010;

    function automatic logic [5:0] ctrl();
        return {hz.pc_we, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush, hz.ex_mem_en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_used = 0; hz.id_rs2_used = 0;
        hz.id_ebreak = 0; hz.ex_rd = '0; hz.ex_is_load = 0; hz.ex_rs1 = '0;
        hz.ex_rs2 = '0; hz.ex_pc_sel = 0; hz.mem_rd = '0; hz.mem_reg_write = 0;
        hz.wb_rd = '0; hz.wb_reg_write = 0; hz.dmem_busy = 0;
    endtask

    task automatic apply(input vec_t v);
        idle();
        hz.id_rs1 = v.id_rs1; hz.id_rs2 = v.id_rs2;
        hz.id_rs1_used = v.rs1u; hz.id_rs2_used = v.rs2u;
        hz.ex_rd = v.ex_rd; hz.ex_is_load = v.ld;
        hz.ex_rs1 = v.ex_rs1; hz.ex_rs2 = v.ex_rs2; hz.ex_pc_sel = v.pcsel;
        hz.mem_rd = v.mem_rd; hz.mem_reg_write = v.mrw;
        hz.wb_rd = v.wb_rd; hz.wb_reg_write = v.wrw;
    endtask

    function automatic int sat7(input int x);
        return (x > 7) ? 7 : x;
    endfunction

    initial begin
        //            rs1 rs2 u1 u2 exrd ld exs1 exs2 br memrd mw wbrd ww  ctrl    fwd
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_IDLE, 4'b0000};
        vecs[1]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_LU,   4'b0000};
        vecs[2]  = '{5'd5, 5'd0, 0, 0, 5'd5, 1, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_IDLE, 4'b0000};
        vecs[3]  = '{5'd0, 5'd9, 0, 1, 5'd9, 1, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_LU,   4'b0000};
        vecs[4]  = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_IDLE, 4'b0000};
        vecs[5]  = '{5'd5, 5'd0, 1, 0, 5'd5, 1, 5'd0, 5'd0, 1, 5'd0, 0, 5'd0, 0, C_BR,   4'b0000};
        vecs[6]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd7, 5'd3, 0, 5'd7, 1, 5'd7, 1, C_IDLE, 4'b0100};
        vecs[7]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd7, 5'd3, 0, 5'd0, 1, 5'd7, 1, C_IDLE, 4'b1000};
        vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd0, 1, C_IDLE, 4'b0000};
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 5'd4, 0, 5'd4, 0, 5'd4, 1, C_IDLE, 4'b0010};
        vecs[10] = '{5'd5, 5'd0, 1, 0, 5'd5, 0, 5'd6, 5'd6, 0, 5'd6, 1, 5'd0, 0, C_IDLE, 4'b0101};

        // Reset: outputs forced even with matching forwarding inputs.
        idle();
        sys_rst = 1'b1;
        hz.mem_rd = 5'd7; hz.mem_reg_write = 1; hz.ex_rs1 = 5'd7;
        tick();
        chk("reset_ctrl", 32'(ctrl()), 32'(C_RST));
        chk("reset_fwd", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'h0);
        chk("reset_stall", stall_cycles, 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        tick();
        sys_rst = 1'b0;
        idle();

        // Single-cycle RUN behaviour from the vector table.
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            #2;
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl()), 32'(vecs[i].exp_ctrl));
            chk($sformatf("vec%0d_fwd", i), 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 32'(vecs[i].exp_fwd));
            if (vecs[i].exp_ctrl[5] == 1'b0) exp_stall++;
            tick();
            chk($sformatf("vec%0d_stall", i), stall_cycles, 32'(exp_stall));
        end
        idle();
        #2;
        chk("after_lu_pc_we", 32'(hz.pc_we), 32'd1);

        // Four busy cycles with a taken branch pending; flush once memory frees.
        hz.ex_pc_sel = 1; hz.dmem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("busy%0d_ctrl", i), 32'(ctrl()), 32'(C_FRZ));
            tick();
        end
        exp_stall += 4;
        hz.dmem_busy = 0;
        #2;
        chk("unfreeze_branch_ctrl", 32'(ctrl()), 32'(C_BR));
        tick();
        idle();
        chk("busy_stall", stall_cycles, 32'(exp_stall));
        chk("sat_stall_mid", 32'(stall_cycles2), 32'(sat7(exp_stall)));

        // ebreak, one busy cycle during drain, halt after 5 cycles.
        hz.id_ebreak = 1;
        #2;
        chk("ebreak_ctrl", 32'(ctrl()), 32'(C_EBRK));
        tick();
        hz.id_ebreak = 0; hz.dmem_busy = 1;
        #2;
        chk("drain_busy_ctrl", 32'(ctrl()), 32'(C_DRNB));
        chk("drain_busy_halted", 32'(halted), 32'd0);
        tick();
        hz.dmem_busy = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("drain%0d_ctrl", i), 32'({ctrl()[5:4], ctrl()[2:0]}), 32'({C_DRN[5:4], C_DRN[2:0]}));
            chk($sformatf("drain%0d_halted", i), 32'(halted), 32'd0);
            tick();
        end
        exp_stall += 5;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_ctrl", 32'(ctrl()), 32'(C_FRZ));
        chk("halt_stall", stall_cycles, 32'(exp_stall));
        // HALT ignores everything but reset; counter stays frozen.
        hz.ex_pc_sel = 1; hz.id_ebreak = 1;
        tick();
        tick();
        chk("halt_hold_halted", 32'(halted), 32'd1);
        chk("halt_hold_ctrl", 32'(ctrl()), 32'(C_FRZ));
        chk("halt_hold_stall", stall_cycles, 32'(exp_stall));
        chk("sat_stall_max", 32'(stall_cycles2), 32'(sat7(exp_stall)));

        // Reset pulsed in HALT.
        idle();
        sys_rst = 1;
        #2;
        chk("rst_in_halt_ctrl", 32'(ctrl()), 32'(C_RST));
        tick();
        sys_rst = 0;
        exp_stall = 0;
        #2;
        chk("post_rst_halted", 32'(halted), 32'd0);
        chk("post_rst_stall", stall_cycles, 32'd0);
        chk("post_rst_ctrl", 32'(ctrl()), 32'(C_IDLE));
        chk("post_rst_sat_stall", 32'(stall_cycles2), 32'd0);
        tick();

        // Reset in the middle of a drain aborts it.
        hz.id_ebreak = 1;
        tick();
        hz.id_ebreak = 0;
        tick();
        sys_rst = 1;
        tick();
        sys_rst = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_mid_drain_halted", 32'(halted), 32'd0);
        chk("rst_mid_drain_ctrl", 32'(ctrl()), 32'(C_IDLE));
        chk("rst_mid_drain_stall", stall_cycles, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
